priority_encoder: RTL and testbench
===================================

// Module: priority_encoder
// PURPOSE
//  - Registered N-to-log2(N) priority encoder. Reports the index of the highest-priority
//    asserted request bit, plus a flag for whether any bit was asserted.
//  - Used as a small arbitration/index helper. Default build: 4 requests, 2-bit index,
//    MSB has highest priority.
// PARAMETERS
//  - WIDTH      4  number of request bits; power of two, >= 2
//  - IDX_W      $clog2(WIDTH) = 2  width of the encoded index
//  - MSB_FIRST  1  1: highest set bit wins; 0: lowest set bit wins
// PORTS
//  - clk    in   1      rising-edge clock; the block's only clock
//  - rst_n  in   1      reset; asynchronous assert, active-low
//  - i      in   WIDTH  request vector, sampled every cycle
//  - y      out  IDX_W  registered index of the winning request bit
//  - valid  out  1      registered; 1 when the sampled i was nonzero
// BEHAVIOUR
//  - Reset: while rst_n = 0, y = 0 and valid = 0 immediately, with no wait for a clock edge.
//    Release from reset is synchronous to the next clk edge after rst_n goes high.
//  - Each rising clk edge: y <= enc(i) and valid <= |i.
//  - Latency is exactly 1 cycle. Throughput is one result per cycle. There is no handshake and no state machine.
//  - MSB_FIRST = 1: enc(i) is the largest k with i[k] = 1.
//    Examples: 0100->10, 1001->11, 0011->01, 1101->11, 0101->10, 0010->01, 0001->00.
//  - MSB_FIRST = 0: enc(i) is the smallest k with i[k] = 1.
//    Examples: 1001->00, 1101->00, 0100->10, 0010->01.
//  - i = 0: y = 0 and valid = 0. Consumers must qualify y with valid.
//  - Single-hot inputs give the same y in both modes.
//  - The output never carries X or Z when i is fully driven. Multi-hot inputs always resolve by priority.
//  - Reset asserted mid-stream clears y and valid at once. The first result after release
//    reflects i sampled at the first edge with rst_n = 1.
// STRUCTURE
//  - Shared package pe_pkg holds:
//    - the default constants PE_WIDTH = 4 and PE_IDX_W = 2
//    - the function clog2_f, used for IDX_W derivation
//  - Sub-module pe_core: purely combinational encoder. Parameters are WIDTH and MSB_FIRST.
//    Ports are i, idx and any. Built as a for-loop scan so that the last match wins.
//  - Top level is pe_core followed by the output register with async active-low reset.
// TESTING
//  1. Reset: rst_n = 0 with i = 1111 -> y = 00 and valid = 0 without any clock edge.
//     Still 0 after 3 edges.
//  2. MSB mode, one vector per cycle: 0100, 0001, 1001, 0011, 1101, 0101, 0010
//     -> one cycle later y = 10, 00, 11, 01, 11, 10, 01, with valid = 1 throughout.
//  3. i = 0000 -> y = 00 and valid = 0. Then i = 1000 -> y = 11 and valid = 1 on the next edge.
//  4. MSB_FIRST = 0 build: 1001 -> 00, 1101 -> 00, 0100 -> 10, 0010 -> 01, 1000 -> 11.
//  5. Exhaustive: all 16 values of i in both modes, each compared against a reference model
//     with a 1-cycle delay.
//  6. Assert rst_n low mid-stream while y = 11 -> y = 00 and valid = 0 immediately.
//     After release, the next edge with i = 0010 gives y = 01.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package pe_pkg;

  localparam int PE_WIDTH = 4;
  localparam int PE_IDX_W = 2;

  // Ceiling log2 for deriving index widths from request counts.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_core.sv
// Combinational priority encoder: index of the winning request bit plus an any-set flag.
module pe_core
  import pe_pkg::*;
#(
  parameter int WIDTH     = PE_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDX_W    = clog2_f(WIDTH)
) (
  input  logic [WIDTH-1:0] i,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // The scan runs toward the highest-priority bit so the last match wins.
  always_comb begin
    idx = '0;
    any = |i;
    for (int k = 0; k < WIDTH; k++) begin
      if (MSB_FIRST) begin
        if (i[k]) idx = IDX_W'(k);
      end else begin
        if (i[WIDTH-1-k]) idx = IDX_W'(WIDTH-1-k);
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: one result per cycle, one cycle of latency.
// y is meaningful only while valid is high; i = 0 yields y = 0, valid = 0.
module priority_encoder
  import pe_pkg::*;
#(
  parameter int WIDTH     = PE_WIDTH,
  parameter int IDX_W     = clog2_f(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  output logic [IDX_W-1:0] y,
  output logic             valid
);

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  pe_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .i   (i),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
    end else begin
      y     <= enc_idx;
      valid <= enc_any;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed bench for priority_encoder, covering MSB-first and LSB-first builds side by side.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] i;
  logic [1:0] y_m, y_l;
  logic       v_m, v_l;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_m_q[$];
  logic [2:0] exp_l_q[$];

  priority_encoder #(.WIDTH(4), .IDX_W(2), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .y     (y_m),
    .valid (v_m)
  );

  priority_encoder #(.WIDTH(4), .IDX_W(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .y     (y_l),
    .valid (v_l)
  );

  // Clock block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model returning {valid, y}, written as a plain priority chain.
  function automatic logic [2:0] model(input logic [3:0] v, input bit msb);
    logic [2:0] r;
    r = 3'b000;
    if (msb) begin
      if      (v[3]) r = 3'b111;
      else if (v[2]) r = 3'b110;
      else if (v[1]) r = 3'b101;
      else if (v[0]) r = 3'b100;
    end else begin
      if      (v[0]) r = 3'b100;
      else if (v[1]) r = 3'b101;
      else if (v[2]) r = 3'b110;
      else if (v[3]) r = 3'b111;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {valid,y}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Driver: apply a vector, let one edge pass, settle away from the edge.
  task automatic drive(input logic [3:0] v);
    i = v;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] msb_vecs [7] = '{4'b0100, 4'b0001, 4'b1001, 4'b0011, 4'b1101, 4'b0101, 4'b0010};
  logic [2:0] msb_exps [7] = '{3'b110, 3'b100, 3'b111, 3'b101, 3'b111, 3'b110, 3'b101};
  logic [3:0] lsb_vecs [5] = '{4'b1001, 4'b1101, 4'b0100, 4'b0010, 4'b1000};
  logic [2:0] lsb_exps [5] = '{3'b100, 3'b100, 3'b110, 3'b101, 3'b111};

  initial begin
    // Reset block: run out of reset with all requests set, then assert reset between edges.
    rst_n = 1'b1;
    i     = 4'b1111;
    @(posedge clk);
    #1;
    check("pre_reset_msb", {v_m, y_m}, 3'b111);
    check("pre_reset_lsb", {v_l, y_l}, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_msb", {v_m, y_m}, 3'b000);
    check("reset_async_lsb", {v_l, y_l}, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_msb", {v_m, y_m}, 3'b000);
    check("reset_held_lsb", {v_l, y_l}, 3'b000);
    #2;
    rst_n = 1'b1;

    // MSB-first directed vectors.
    for (int k = 0; k < 7; k++) begin
      drive(msb_vecs[k]);
      check($sformatf("msb_vec_%b", msb_vecs[k]), {v_m, y_m}, msb_exps[k]);
    end

    // Zero input, then a lone top bit.
    drive(4'b0000);
    check("zero_msb", {v_m, y_m}, 3'b000);
    check("zero_lsb", {v_l, y_l}, 3'b000);
    drive(4'b1000);
    check("top_bit_msb", {v_m, y_m}, 3'b111);

    // LSB-first directed vectors.
    for (int k = 0; k < 5; k++) begin
      drive(lsb_vecs[k]);
      check($sformatf("lsb_vec_%b", lsb_vecs[k]), {v_l, y_l}, lsb_exps[k]);
    end

    // Exhaustive sweep against the model through the scoreboard queues.
    for (int v = 0; v < 16; v++) begin
      exp_m_q.push_back(model(4'(v), 1'b1));
      exp_l_q.push_back(model(4'(v), 1'b0));
      drive(4'(v));
      check($sformatf("sweep_msb_%0d", v), {v_m, y_m}, exp_m_q.pop_front());
      check($sformatf("sweep_lsb_%0d", v), {v_l, y_l}, exp_l_q.pop_front());
    end

    // Mid-stream reset while y = 11, then first result after release.
    drive(4'b1000);
    check("pre_midreset_msb", {v_m, y_m}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_msb", {v_m, y_m}, 3'b000);
    check("midreset_lsb", {v_l, y_l}, 3'b000);
    @(negedge clk);
    i     = 4'b0010;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_msb", {v_m, y_m}, 3'b101);
    check("release_lsb", {v_l, y_l}, 3'b101);

    // Random sweep with randomly placed single-hot vectors, both modes agree.
    for (int k = 0; k < 8; k++) begin
      logic [3:0] v;
      v = 4'b0001 << $urandom_range(3, 0);
      drive(v);
      check($sformatf("onehot_agree_%b", v), {v_m, y_m}, {v_l, y_l});
      check($sformatf("onehot_msb_%b", v), {v_m, y_m}, model(v, 1'b1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
